corebootstrap_ahb_mem_slave: RTL and testbench
==============================================

# corebootstrap_ahb_mem_slave

AHB-Lite subordinate with a register-based word memory: the responder end for the bootstrap AHB writer. It accepts the writer's single 32-bit write transfers, then its final read-back check, on the same bus. It provides configurable wait states, a two-cycle ERROR response for illegal accesses, and a completed-write counter for boot-progress observation.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0. Must be 4-byte aligned.
- `MEM_DEPTH`, default 256: number of 32-bit words. Power of two, 4..4096.
- `WAIT_STATES`, default 0: data-phase wait cycles per OKAY transfer, 0..7.
- `HCLK` in 1: sole clock, rising edge.
- `HRESETN` in 1: reset, asynchronous assert, active-low.
- `HSEL` in 1: slave select.
- `HADDR` in 32: byte address.
- `HTRANS` in 2: transfer type; bit 1 = NONSEQ/SEQ.
- `HWRITE` in 1: 1 = write.
- `HSIZE` in 3: transfer size; only 3'b010 is legal.
- `HBURST` in 3: ignored; every beat is treated as a single transfer.
- `HWDATA` in 32: write data, valid in the data phase.
- `HREADY` in 1: bus-level ready, used to qualify the address phase.
- `HREADYOUT` out 1: slave ready.
- `HRESP` out 1: 1 = ERROR.
- `HRDATA` out 32: read data.
- `wr_count` out 16: count of completed OKAY writes, saturating.

## Operation
- An address phase is accepted at a rising edge when `HSEL & HREADY & HTRANS[1]`. On acceptance the block registers the write flag, the word index `(HADDR-BASE_ADDR)>>2` and a legality flag. IDLE and BUSY transfers, and unselected cycles, get a zero-wait OKAY and cause no action.
- A transfer is illegal if any of the following hold:
  - `HADDR < BASE_ADDR`
  - `HADDR-BASE_ADDR >= 4*MEM_DEPTH`
  - `HADDR[1:0] != 0`
  - `HSIZE != 3'b010`
- An illegal transfer never touches memory and never changes `wr_count`.
- State machine:
  - S_IDLE: `HREADYOUT=1`, `HRESP=0`.
    - Accepted legal transfer -> S_DATA, wait counter = `WAIT_STATES`.
    - Accepted illegal transfer -> S_ERR1.
  - S_DATA: `HREADYOUT = (cnt==0)`, `HRESP=0`. While cnt != 0, cnt decrements each cycle.
    - When cnt==0 the transfer completes at that edge. For a write, `mem[idx] <= HWDATA` and `wr_count` increments, saturating at 16'hFFFF.
    - At that same edge, a newly accepted legal transfer re-enters S_DATA with the counter reloaded; an illegal one goes to S_ERR1; otherwise -> S_IDLE.
  - S_ERR1: `HREADYOUT=0`, `HRESP=1`. Always -> S_ERR2.
  - S_ERR2: `HREADYOUT=1`, `HRESP=1`. Accepting a new transfer follows the same rules as S_IDLE; otherwise -> S_IDLE.
- `HRDATA = mem[idx]` in S_DATA for a read with cnt==0; otherwise 32'h0.
- Memory is not reset. Contents survive `HRESETN` assertion.

## Timing
- Reset values: state S_IDLE, `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`, `wr_count=0`, cnt=0.
- Asserting `HRESETN` mid-transfer aborts the transfer with no memory write. All outputs return to their reset values asynchronously.
- OKAY latency: the data phase lasts `WAIT_STATES+1` cycles after the address-phase edge.
- Write data is sampled only at the completing edge, so `HWDATA` changes during wait states are ignored.
- A read whose address phase coincides with the data phase of a write to the same word returns the new data. The write commits at the edge that starts the read's data phase, so no forwarding is required.
- ERROR is always exactly 2 data-phase cycles, independent of `WAIT_STATES`. `HRESP` stays high in both cycles.
- `HRDATA`, `HREADYOUT` and `HRESP` are decoded from registered state only. There is no combinational path from `HADDR` or `HTRANS`.
- Back-to-back legal transfers with `WAIT_STATES=0` sustain one transfer per cycle.

## Test plan
- **Zero-wait write/read:** `WAIT_STATES=0`. Write 32'hDEADBEEF to `BASE_ADDR+0x10`, then read it pipelined in the next cycle -> `HREADYOUT` never low, `HRDATA`=32'hDEADBEEF in the read data phase, `wr_count`=1.
- **Wait states:** `WAIT_STATES=2`. Write 32'h1234_5678 to `BASE_ADDR+0` -> `HREADYOUT` low for exactly 2 cycles, then high. Change `HWDATA` during the wait cycles -> the final-cycle value is stored.
- **Out of range:** `MEM_DEPTH=256`, write to `BASE_ADDR+0x400` -> `HREADYOUT=0/HRESP=1`, then `HREADYOUT=1/HRESP=1`. Memory unchanged, `wr_count` unchanged.
- **Unaligned and wrong size:** read at `BASE_ADDR+0x2` -> two-cycle ERROR. Write with `HSIZE=3'b001` -> two-cycle ERROR. A following legal read returns the prior contents.
- **Boot sequence:** 64 consecutive word writes with incrementing addresses and IDLE gaps, then a read of word 0 -> `wr_count`=64, `HRDATA` equals the first word written.
- **Reset mid-operation:** assert `HRESETN` during the second wait cycle of a write (`WAIT_STATES=3`) -> outputs return to reset values immediately. The target word is unchanged, and `wr_count` keeps its pre-reset value until the reset clears it to 0.

Source files
------------

// File: rtl/corebootstrap_ahb_mem_slave.sv
// AHB-Lite word-memory subordinate that answers the bootstrap writer's write and read-back traffic.
// Provides configurable OKAY wait states, a two-cycle ERROR response and a saturating completed-write counter.
module corebootstrap_ahb_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [15:0] wr_count
);

  localparam int          IDX_W = $clog2(MEM_DEPTH);
  localparam logic [31:0] SPAN  = 32'(4 * MEM_DEPTH);
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        wr_count_q, wr_count_d;
  logic [31:0]        mem_q [MEM_DEPTH];

  logic [31:0] offset;
  logic        accept, legal, done, commit, slot_open;

  // Burst type and the SEQ/NONSEQ distinction carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HTRANS[0]};

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign offset    = HADDR - BASE_ADDR;
  assign legal     = (HADDR >= BASE_ADDR) && (offset < SPAN) &&
                     (HADDR[1:0] == 2'b00) && (HSIZE == 3'b010);
  assign done      = (state_q == S_DATA) && (cnt_q == 3'd0);
  assign commit    = done && write_q;
  // A new address phase can only be taken when the bus is not being stalled by us.
  assign slot_open = (state_q == S_IDLE) || (state_q == S_ERR2) || done;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    idx_d      = idx_q;
    wr_count_d = wr_count_q;

    if (commit && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end

    case (state_q)
      S_DATA: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               state_d = S_IDLE;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    if (accept && slot_open) begin
      if (legal) begin
        state_d = S_DATA;
        cnt_d   = WS;
        write_d = HWRITE;
        idx_d   = offset[IDX_W+1:2];
      end else begin
        state_d = S_ERR1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      wr_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      idx_q      <= idx_d;
      wr_count_q <= wr_count_d;
    end
  end

  // NOTE: the memory has no reset so contents survive HRESETN; reset holds state_q in S_IDLE, which blocks commits.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      mem_q[idx_q] <= HWDATA;
    end
  end

  assign HREADYOUT = !((state_q == S_ERR1) || ((state_q == S_DATA) && (cnt_q != 3'd0)));
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATA    = (done && !write_q) ? mem_q[idx_q] : 32'h0;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_corebootstrap_ahb_mem_slave.sv
// Self-checking bench: three subordinates (0, 2 and 3 wait states) on a shared pipelined AHB driver,
// table-driven vectors with a response scoreboard plus hand-written reset-abort sequence.
module tb_corebootstrap_ahb_mem_slave;

  localparam logic [31:0] BASE = 32'h2000_0000;

  typedef enum logic [1:0] {OP_IDLE, OP_RD, OP_WR} op_e;

  typedef struct {
    op_e         kind;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] junk;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          idx;
    logic        exp_err;
    logic        is_rd;
    logic [31:0] exp_rdata;
    int          exp_waits;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0;
  logic        hwrite = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [31:0] hwdata = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'b010;
  logic [2:0]  hburst = 3'b000;

  logic [1:0]  cur = 2'd0;
  int          ws_cur = 0;

  logic [2:0]  ro_ready, ro_resp;
  logic [31:0] ro_rdata [3];
  logic [15:0] ro_cnt   [3];

  logic        hready, hresp_m;
  logic [31:0] hrdata_m;
  logic [15:0] wrc_m;

  assign hready   = ro_ready[cur];
  assign hresp_m  = ro_resp[cur];
  assign hrdata_m = ro_rdata[cur];
  assign wrc_m    = ro_cnt[cur];

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];
  exp_t sb_q[$];

  always #5 hclk = ~hclk;

  corebootstrap_ahb_mem_slave #(.BASE_ADDR(BASE), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .HCLK(hclk), .HRESETN(hresetn), .HSEL(hsel && (cur == 2'd0)), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro_ready[0]), .HRESP(ro_resp[0]), .HRDATA(ro_rdata[0]), .wr_count(ro_cnt[0]));

  corebootstrap_ahb_mem_slave #(.BASE_ADDR(BASE), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut2 (
    .HCLK(hclk), .HRESETN(hresetn), .HSEL(hsel && (cur == 2'd1)), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro_ready[1]), .HRESP(ro_resp[1]), .HRDATA(ro_rdata[1]), .wr_count(ro_cnt[1]));

  corebootstrap_ahb_mem_slave #(.BASE_ADDR(BASE), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut3 (
    .HCLK(hclk), .HRESETN(hresetn), .HSEL(hsel && (cur == 2'd2)), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro_ready[2]), .HRESP(ro_resp[2]), .HRDATA(ro_rdata[2]), .wr_count(ro_cnt[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input op_e kind, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input logic [31:0] junk,
                         input logic exp_err, input logic [31:0] exp_rdata);
    vec_t v;
    v.kind = kind; v.addr = addr; v.size = size; v.wdata = wdata; v.junk = junk;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] boot_word(input int k);
    return 32'hB007_0000 | 32'(k);
  endfunction

  // Pipelined master: entered and left at posedge+1. Expectations are queued at address acceptance
  // and popped when the data phase completes.
  task automatic run_table(input string tag);
    int   i = 0;
    int   waits = 0;
    int   budget = 0;
    bit   dp_v = 1'b0;
    bit   rdy;
    vec_t dp;
    exp_t e;
    while ((i < tbl.size() || dp_v) && budget < 4000) begin
      budget++;
      if (i < tbl.size() && tbl[i].kind != OP_IDLE) begin
        hsel = 1'b1; htrans = 2'b10; haddr = tbl[i].addr; hsize = tbl[i].size;
        hwrite = (tbl[i].kind == OP_WR);
      end else begin
        hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hsize = 3'b010; hwrite = 1'b0;
      end
      hwdata = dp_v ? (hready ? dp.wdata : dp.junk) : 32'h0;
      @(negedge hclk);
      rdy = hready;
      if (dp_v) begin
        if (!rdy) begin
          waits++;
          if (dp.exp_err) check($sformatf("%s v%0d err-wait hresp", tag, i - 1), 32'(hresp_m), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("%s v%0d hresp", tag, e.idx), 32'(hresp_m), 32'(e.exp_err));
          check($sformatf("%s v%0d waits", tag, e.idx), 32'(waits), 32'(e.exp_waits));
          if (e.is_rd && !e.exp_err)
            check($sformatf("%s v%0d hrdata", tag, e.idx), hrdata_m, e.exp_rdata);
          dp_v = 1'b0;
        end
      end
      @(posedge hclk);
      if (rdy && i < tbl.size()) begin
        if (tbl[i].kind != OP_IDLE) begin
          e.idx       = i;
          e.exp_err   = tbl[i].exp_err;
          e.is_rd     = (tbl[i].kind == OP_RD);
          e.exp_rdata = tbl[i].exp_rdata;
          e.exp_waits = tbl[i].exp_err ? 1 : ws_cur;
          sb_q.push_back(e);
          dp   = tbl[i];
          dp_v = 1'b1;
          waits = 0;
        end
        i++;
      end
      #1;
    end
    check($sformatf("%s vectors issued", tag), 32'(i), 32'(tbl.size()));
    check($sformatf("%s scoreboard drained", tag), 32'(sb_q.size()), 32'd0);
    tbl.delete();
    sb_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset dut%0d hreadyout", k), 32'(ro_ready[k]), 32'd1);
      check($sformatf("reset dut%0d hresp", k), 32'(ro_resp[k]), 32'd0);
      check($sformatf("reset dut%0d hrdata", k), ro_rdata[k], 32'h0);
      check($sformatf("reset dut%0d wr_count", k), 32'(ro_cnt[k]), 32'd0);
    end
    #20 hresetn = 1'b1;
    @(posedge hclk); #1;

    // Zero-wait traffic, range / alignment / size errors.
    cur = 2'd0; ws_cur = 0;
    add_vec(OP_WR,   BASE + 32'h010, 3'b010, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0);
    add_vec(OP_RD,   BASE + 32'h010, 3'b010, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF);
    add_vec(OP_IDLE, 32'h0,          3'b010, 32'h0, 32'h0, 1'b0, 32'h0);
    add_vec(OP_WR,   BASE + 32'h000, 3'b010, 32'h0102_0304, 32'h0, 1'b0, 32'h0);
    add_vec(OP_WR,   BASE + 32'h3FC, 3'b010, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h0);
    add_vec(OP_WR,   BASE + 32'h400, 3'b010, 32'hAAAA_5555, 32'h0, 1'b1, 32'h0);
    add_vec(OP_RD,   BASE - 32'h004, 3'b010, 32'h0, 32'h0, 1'b1, 32'h0);
    add_vec(OP_RD,   BASE + 32'h000, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0102_0304);
    add_vec(OP_RD,   BASE + 32'h3FC, 3'b010, 32'h0, 32'h0, 1'b0, 32'hCAFE_F00D);
    add_vec(OP_RD,   BASE + 32'h012, 3'b010, 32'h0, 32'h0, 1'b1, 32'h0);
    add_vec(OP_WR,   BASE + 32'h010, 3'b001, 32'h1111_1111, 32'h0, 1'b1, 32'h0);
    add_vec(OP_RD,   BASE + 32'h010, 3'b010, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF);
    run_table("ws0");
    check("ws0 wr_count", 32'(wrc_m), 32'd3);

    // Two wait states; write data changes during the waits, only the last value lands.
    cur = 2'd1; ws_cur = 2;
    add_vec(OP_WR, BASE + 32'h000, 3'b010, 32'h1234_5678, 32'hFFFF_0000, 1'b0, 32'h0);
    add_vec(OP_RD, BASE + 32'h000, 3'b010, 32'h0, 32'h0, 1'b0, 32'h1234_5678);
    add_vec(OP_WR, BASE + 32'h008, 3'b001, 32'h9999_9999, 32'h0, 1'b1, 32'h0);
    add_vec(OP_RD, BASE + 32'h000, 3'b010, 32'h0, 32'h0, 1'b0, 32'h1234_5678);
    run_table("ws2");
    check("ws2 wr_count", 32'(wrc_m), 32'd1);

    // Boot sequence on the three-wait-state instance.
    cur = 2'd2; ws_cur = 3;
    for (int k = 0; k < 64; k++) begin
      add_vec(OP_WR,   BASE + 32'(4 * k), 3'b010, boot_word(k), 32'h0BAD_0BAD, 1'b0, 32'h0);
      add_vec(OP_IDLE, 32'h0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0);
    end
    add_vec(OP_RD, BASE + 32'h000, 3'b010, 32'h0, 32'h0, 1'b0, boot_word(0));
    add_vec(OP_RD, BASE + 32'h0FC, 3'b010, 32'h0, 32'h0, 1'b0, boot_word(63));
    run_table("boot");
    check("boot wr_count", 32'(wrc_m), 32'd64);

    // Reset asserted during the second wait cycle of a write to word 5.
    hsel = 1'b1; htrans = 2'b10; haddr = BASE + 32'h014; hwrite = 1'b1; hsize = 3'b010;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hwdata = 32'h5555_AAAA;
    @(posedge hclk); #1;
    check("abort wait2 hreadyout", 32'(hready), 32'd0);
    check("abort pre-reset wr_count", 32'(wrc_m), 32'd64);
    #2 hresetn = 1'b0;
    #1;
    check("abort hreadyout", 32'(hready), 32'd1);
    check("abort hresp", 32'(hresp_m), 32'd0);
    check("abort hrdata", hrdata_m, 32'h0);
    check("abort wr_count", 32'(wrc_m), 32'd0);
    repeat (2) @(posedge hclk);
    @(negedge hclk) hresetn = 1'b1;
    @(posedge hclk); #1;
    add_vec(OP_RD, BASE + 32'h014, 3'b010, 32'h0, 32'h0, 1'b0, boot_word(5));
    add_vec(OP_RD, BASE + 32'h000, 3'b010, 32'h0, 32'h0, 1'b0, boot_word(0));
    run_table("post-reset");
    check("post-reset wr_count", 32'(wrc_m), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
